fsm_mem_access: RTL and testbench

FSM_MEM_ACCESS -- requirements
Module: fsm_mem_access

---
 rtl/cu_pkg.sv | 68 ++++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/fsm_mem_access.sv | 164 ++++++++++++++++
 tb/tb_fsm_mem_access.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the memory-access control unit: FSM states, trap causes,
// access sizes, opdecoder bit positions and the alignment/size legality helpers.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WRITEBACK,
        ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10,
        CAUSE_ILL_SIZE = 2'b11
    } trap_cause_t;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    localparam logic [1:0] SEL_RD_MEM = 2'b00;
    localparam logic [1:0] SEL_RD_IMM = 2'b01;

    localparam int CODE_LOAD  = 0;
    localparam int CODE_STORE = 8;
    localparam int CODE_LUI   = 13;

    // Registered control outputs, kept together so they share one register.
    typedef struct packed {
        logic       load_rs1;
        logic       load_rs2;
        logic       load_imm;
        logic       load_alu;
        logic       load_data_memory;
        logic       load_regfile;
        logic       load_pc;
        logic       mem_req;
        logic       write_mem;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic [1:0] sel_rd;
        logic       busy;
        logic       done;
        logic       trap;
        logic [1:0] trap_cause;
    } ctrl_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
        case (size)
            SIZE_HALF:   return addr[0];
            SIZE_WORD:   return addr[1:0] != 2'b00;
            SIZE_DOUBLE: return addr != 3'b000;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic illegal_size(input logic [1:0] size, input logic uns,
                                          input logic xlen32);
        return (size == SIZE_DOUBLE) && (xlen32 || uns);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; saturates at WAIT_MAX and flags
// expiry once the limit is reached.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

    logic [7:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/fsm_mem_access.sv
// Load/store/lui control FSM with registered outputs decoded from the next state.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses (cause 01).
module fsm_mem_access
    import cu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ins,
    input  logic [31:0] code,
    input  logic [2:0]  addr_lo,
    input  logic        mem_ready,
    output logic        load_rs1,
    output logic        load_rs2,
    output logic        load_imm,
    output logic        load_alu,
    output logic        load_data_memory,
    output logic        load_regfile,
    output logic        load_pc,
    output logic        mem_req,
    output logic        write_mem,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic [1:0]  sel_rd,
    output logic        busy,
    output logic        done,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic XLEN_IS_32 = (XLEN == 32);

    state_t      state_q, state_d;
    trap_cause_t cause_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        timer_clear, timer_en, timer_expired;
    logic        size_illegal, addr_misaligned;
    logic        unused_inputs;

    // Legality is judged on the size latched in DECODE, not the live instruction.
    assign size_illegal = illegal_size(ctrl_q.mem_size, ctrl_q.mem_unsigned, XLEN_IS_32);

`ifdef MEM_MISALIGN_TRAP_EN
    assign addr_misaligned = misaligned(ctrl_q.mem_size, addr_lo);
    assign unused_inputs   = ^{ins[31:15], ins[11:0], code[31:14], code[12:9], code[7:1]};
`else
    assign addr_misaligned = 1'b0;
    assign unused_inputs   = ^{ins[31:15], ins[11:0], code[31:14], code[12:9], code[7:1],
                               addr_lo};
`endif

    // The request cycle itself is counted, so the timer reads k in the k-th wait cycle.
    assign timer_clear = (state_d == ST_MEM_REQ);
    assign timer_en    = (state_q == ST_MEM_REQ) || (state_q == ST_MEM_WAIT);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_DECODE;
            ST_DECODE:   state_d = code[CODE_LUI] ? ST_WRITEBACK : ST_EXECUTE;
            ST_EXECUTE: begin
                if (size_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILL_SIZE;
                end else if (addr_misaligned) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MISALIGN;
                end else begin
                    state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ:  state_d = mem_ready ? ST_WRITEBACK : ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // load_data_memory lands in WRITEBACK, the cycle after the acknowledge of a load.
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.busy = (state_d != ST_IDLE);
        if (state_d == ST_DECODE) begin
            ctrl_d.mem_size     = ins[13:12];
            ctrl_d.mem_unsigned = ins[14];
        end else if (state_d != ST_IDLE) begin
            ctrl_d.mem_size     = ctrl_q.mem_size;
            ctrl_d.mem_unsigned = ctrl_q.mem_unsigned;
        end
        case (state_d)
            ST_DECODE: begin
                ctrl_d.load_rs1 = 1'b1;
                ctrl_d.load_rs2 = 1'b1;
                ctrl_d.load_imm = 1'b1;
            end
            ST_EXECUTE:  ctrl_d.load_alu = 1'b1;
            ST_MEM_REQ, ST_MEM_WAIT: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.write_mem = code[CODE_STORE];
            end
            ST_WRITEBACK: begin
                ctrl_d.load_pc          = 1'b1;
                ctrl_d.done             = 1'b1;
                ctrl_d.load_regfile     = code[CODE_LOAD] | code[CODE_LUI];
                ctrl_d.sel_rd           = code[CODE_LUI] ? SEL_RD_IMM : SEL_RD_MEM;
                ctrl_d.load_data_memory = code[CODE_LOAD] &&
                                          ((state_q == ST_MEM_REQ) || (state_q == ST_MEM_WAIT));
            end
            ST_TRAP: begin
                ctrl_d.trap       = 1'b1;
                ctrl_d.trap_cause = cause_d;
            end
            default: ;
        endcase
    end

    assign load_rs1         = ctrl_q.load_rs1;
    assign load_rs2         = ctrl_q.load_rs2;
    assign load_imm         = ctrl_q.load_imm;
    assign load_alu         = ctrl_q.load_alu;
    assign load_data_memory = ctrl_q.load_data_memory;
    assign load_regfile     = ctrl_q.load_regfile;
    assign load_pc          = ctrl_q.load_pc;
    assign mem_req          = ctrl_q.mem_req;
    assign write_mem        = ctrl_q.write_mem;
    assign mem_size         = ctrl_q.mem_size;
    assign mem_unsigned     = ctrl_q.mem_unsigned;
    assign sel_rd           = ctrl_q.sel_rd;
    assign busy             = ctrl_q.busy;
    assign done             = ctrl_q.done;
    assign trap             = ctrl_q.trap;
    assign trap_cause       = ctrl_q.trap_cause;

endmodule

// File: tb/tb_fsm_mem_access.sv
// Randomized bench for fsm_mem_access: an XLEN=64 and an XLEN=32 instance share
// stimulus and are compared every cycle against a per-transaction timeline model.
module tb_fsm_mem_access;

    localparam int WMAX = 15;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct packed {
        logic       load_rs1, load_rs2, load_imm, load_alu, load_data_memory;
        logic       load_regfile, load_pc, mem_req, write_mem;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic [1:0] sel_rd;
        logic       busy, done, trap;
        logic [1:0] trap_cause;
    } out_t;

    // kind: 0 load, 1 store, 2 lui; d: request cycle index that sees mem_ready (>WMAX: never)
    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] f3;
        logic [2:0] addr;
        logic [7:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [31:0] ins, code;
    logic [2:0]  addr_lo;

    logic a_rs1, a_rs2, a_imm, a_alu, a_ldm, a_rf, a_pc, a_mreq, a_wr, a_uns, a_busy, a_done, a_trap;
    logic [1:0] a_size, a_sel, a_cause;
    logic b_rs1, b_rs2, b_imm, b_alu, b_ldm, b_rf, b_pc, b_mreq, b_wr, b_uns, b_busy, b_done, b_trap;
    logic [1:0] b_size, b_sel, b_cause;

    out_t act64, act32, exp64, exp32;
    int   vectors = 0, errors = 0, cur_t = 0;
    bit   chk_en = 1'b0;

    assign act64 = {a_rs1, a_rs2, a_imm, a_alu, a_ldm, a_rf, a_pc, a_mreq, a_wr,
                    a_size, a_uns, a_sel, a_busy, a_done, a_trap, a_cause};
    assign act32 = {b_rs1, b_rs2, b_imm, b_alu, b_ldm, b_rf, b_pc, b_mreq, b_wr,
                    b_size, b_uns, b_sel, b_busy, b_done, b_trap, b_cause};

    always #5 clk = ~clk;

    fsm_mem_access #(.XLEN(64), .WAIT_MAX(WMAX)) u_dut64 (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .code(code), .addr_lo(addr_lo),
        .mem_ready(mem_ready), .load_rs1(a_rs1), .load_rs2(a_rs2), .load_imm(a_imm),
        .load_alu(a_alu), .load_data_memory(a_ldm), .load_regfile(a_rf), .load_pc(a_pc),
        .mem_req(a_mreq), .write_mem(a_wr), .mem_size(a_size), .mem_unsigned(a_uns),
        .sel_rd(a_sel), .busy(a_busy), .done(a_done), .trap(a_trap), .trap_cause(a_cause)
    );

    fsm_mem_access #(.XLEN(32), .WAIT_MAX(WMAX)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .code(code), .addr_lo(addr_lo),
        .mem_ready(mem_ready), .load_rs1(b_rs1), .load_rs2(b_rs2), .load_imm(b_imm),
        .load_alu(b_alu), .load_data_memory(b_ldm), .load_regfile(b_rf), .load_pc(b_pc),
        .mem_req(b_mreq), .write_mem(b_wr), .mem_size(b_size), .mem_unsigned(b_uns),
        .sel_rd(b_sel), .busy(b_busy), .done(b_done), .trap(b_trap), .trap_cause(b_cause)
    );

    function automatic txn_t mk(input int kind, input int f3, input int addr, input int d);
        txn_t x;
        x.kind = 2'(kind);
        x.f3   = 3'(f3);
        x.addr = 3'(addr);
        x.d    = 8'(d);
        return x;
    endfunction

    function automatic logic [1:0] cause_of(input int xlen, input txn_t x);
        int size;
        size = int'(x.f3[1:0]);
        if (x.kind == 2'd2) return 2'b00;
        if (size == 3 && (xlen == 32 || x.f3[2])) return 2'b11;
        if (MIS_EN) begin
            if (size == 1 && (x.addr % 2) != 0) return 2'b01;
            if (size == 2 && (x.addr % 4) != 0) return 2'b01;
            if (size == 3 && x.addr != 0) return 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic int last_req(input txn_t x);
        return (int'(x.d) <= WMAX) ? int'(x.d) : WMAX;
    endfunction

    // Number of busy cycles after the edge that accepts start.
    function automatic int busy_len(input int xlen, input txn_t x);
        if (x.kind == 2'd2) return 2;
        if (cause_of(xlen, x) != 2'b00) return 3;
        return 4 + last_req(x);
    endfunction

    // Expected outputs in the t-th cycle after the edge that accepts start (t=0: before).
    function automatic out_t exp_row(input int xlen, input txn_t x, input int t);
        out_t       r;
        logic [1:0] c;
        int         j;
        r = '0;
        c = cause_of(xlen, x);
        if (t < 1 || t > busy_len(xlen, x)) return r;
        r.busy         = 1'b1;
        r.mem_size     = x.f3[1:0];
        r.mem_unsigned = x.f3[2];
        if (t == 1) begin
            r.load_rs1 = 1'b1; r.load_rs2 = 1'b1; r.load_imm = 1'b1;
            return r;
        end
        if (x.kind == 2'd2) begin
            r.load_pc = 1'b1; r.done = 1'b1; r.load_regfile = 1'b1; r.sel_rd = 2'b01;
            return r;
        end
        if (t == 2) begin
            r.load_alu = 1'b1;
            return r;
        end
        if (c != 2'b00) begin
            r.trap = 1'b1; r.trap_cause = c;
            return r;
        end
        j = t - 3;
        if (j <= last_req(x)) begin
            r.mem_req   = 1'b1;
            r.write_mem = (x.kind == 2'd1);
            return r;
        end
        if (int'(x.d) <= WMAX) begin
            r.load_pc          = 1'b1;
            r.done             = 1'b1;
            r.load_regfile     = (x.kind == 2'd0);
            r.load_data_memory = (x.kind == 2'd0);
        end else begin
            r.trap = 1'b1; r.trap_cause = 2'b10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            vectors += 2;
            if (act64 !== exp64) begin
                errors++;
                $display("FAIL cmp64 row %0d: got %05h, required %05h", cur_t, act64, exp64);
            end
            if (act32 !== exp32) begin
                errors++;
                $display("FAIL cmp32 row %0d: got %05h, required %05h", cur_t, act32, exp32);
            end
        end
    end

    task automatic run_txn(input txn_t x, input int stop_row);
        int n64, n32, nmin, last;
        n64  = busy_len(64, x);
        n32  = busy_len(32, x);
        nmin = (n64 < n32) ? n64 : n32;
        last = ((n64 > n32) ? n64 : n32) + 1;
        if (stop_row >= 0) last = stop_row;
        ins         = $urandom;
        ins[14:12]  = x.f3;
        code        = 32'd1 << ((x.kind == 2'd0) ? 0 : (x.kind == 2'd1) ? 8 : 13);
        addr_lo     = x.addr;
        for (int t = 0; t <= last; t++) begin
            cur_t     = t;
            exp64     = exp_row(64, x, t);
            exp32     = exp_row(32, x, t);
            start     = (t == 0) ? 1'b1 : (t <= nmin) ? ($urandom_range(0, 3) == 0) : 1'b0;
            mem_ready = (t < 3) ? 1'($urandom_range(0, 1)) : (t == 3 + int'(x.d));
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        txn_t x;
        out_t r;
        int   cnt;

        // Hand-computed anchors for the model itself.
        x = mk(0, 3'b010, 0, 0);
        check("pin_lw_len", 32'(busy_len(64, x)), 32'd4);
        r = exp_row(64, x, 4);
        check("pin_lw_done", {r.done, r.load_regfile, r.mem_size}, 32'b1110);
        x = mk(1, 3'b011, 0, 3);
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            r = exp_row(64, x, t);
            if (r.write_mem) cnt++;
        end
        check("pin_sd_write_cycles", 32'(cnt), 32'd4);
        r = exp_row(64, x, 7);
        check("pin_sd_wb", {r.done, r.load_regfile}, 32'b10);
        r = exp_row(32, mk(0, 3'b011, 0, 0), 3);
        check("pin_ld32_trap", {r.trap, r.trap_cause}, 32'b111);
        r = exp_row(64, mk(2, 3'b101, 0, 0), 2);
        check("pin_lui_wb", {r.done, r.sel_rd, r.load_regfile}, 32'b1011);
        x = mk(0, 3'b010, 0, 99);
        cnt = 0;
        for (int t = 4; t < 40; t++) begin
            r = exp_row(64, x, t);
            if (r.mem_req) cnt++;
        end
        check("pin_timeout_waits", 32'(cnt), 32'd15);
        r = exp_row(64, x, 19);
        check("pin_timeout_cause", {r.trap, r.trap_cause}, 32'b110);
        r = exp_row(64, x, 20);
        check("pin_timeout_idle", 32'(r.busy), 32'd0);
        r = exp_row(64, mk(0, 3'b001, 1, 0), 3);
        check("pin_lh_misaligned", {r.trap, r.trap_cause, r.mem_req},
              MIS_EN ? 32'b1010 : 32'b0001);

        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; ins = '0; code = '0; addr_lo = '0;
        #1;
        check("reset_state64", 32'(act64), 32'd0);
        check("reset_state32", 32'(act32), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        exp64  = '0;
        exp32  = '0;
        chk_en = 1'b1;

        run_txn(mk(0, 3'b010, 0, 0), -1);     // lw, immediate acknowledge
        run_txn(mk(1, 3'b011, 0, 3), -1);     // sd, ack after 3 cycles
        run_txn(mk(0, 3'b001, 1, 1), -1);     // lh misaligned
        run_txn(mk(0, 3'b011, 0, 2), -1);     // ld: completes at 64, traps at 32
        run_txn(mk(2, 3'b110, 5, 0), -1);     // lui
        run_txn(mk(0, 3'b010, 0, 99), -1);    // timeout
        run_txn(mk(0, 3'b111, 0, 0), -1);     // unsigned double: illegal
        run_txn(mk(0, 3'b100, 7, WMAX), -1);  // ack in the last wait cycle
        run_txn(mk(1, 3'b010, 4, 16), -1);    // ack one cycle too late

        for (int i = 0; i < 80; i++) begin
            x.kind = 2'($urandom_range(0, 2));
            x.f3   = 3'($urandom_range(0, 7));
            x.addr = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7));
            x.d    = 8'($urandom_range(0, WMAX + 2));
            run_txn(x, -1);
        end

        // Asynchronous reset in the middle of a wait.
        run_txn(mk(0, 3'b010, 0, 200), 5);
        chk_en = 1'b0;
        #1;
        check("mem_req_before_rst", 32'(a_mreq), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mem_req64", 32'(a_mreq), 32'd0);
        check("rst_busy64", 32'(a_busy), 32'd0);
        check("rst_all64", 32'(act64), 32'd0);
        check("rst_all32", 32'(act32), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp64  = '0;
        exp32  = '0;
        chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
